kf_step_seq: RTL

Sequencer for one Kalman-filter time step. It accepts a measurement-valid handshake and runs three stage engines in order through start/done pulse handshakes: process-noise (Q) computation, then predict, then update. It holds the previous-step state registers that the Q stage differences against, and it commits them when a step finishes. It sits between the measurement front end and the KF datapath stage blocks, and is the only block that drives their `start` inputs.

---
 rtl/kf_step_seq_if.sv | 38 +++
 rtl/kf_step_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/kf_step_seq_if.sv
// kf_step_seq_if: measurement handshake, stage start/done pulses and state buses
// between the Kalman step sequencer and its neighbours.
`ifndef FXP_N
`define FXP_N 16
`endif
interface kf_step_seq_if #(
    parameter int N     = `FXP_N,
    parameter int CNT_W = 16
);
    logic             meas_valid;
    logic             meas_ready;
    logic [N-1:0]     x00_now;
    logic [N-1:0]     x01_now;
    logic [N-1:0]     x00_prev;
    logic [N-1:0]     x01_prev;
    logic             q_start;
    logic             pred_start;
    logic             upd_start;
    logic             q_done;
    logic             pred_done;
    logic             upd_done;
    logic             busy;
    logic             step_done;
    logic             err_tmo;
    logic [CNT_W-1:0] step_cnt;

    modport slave (
        input  meas_valid, x00_now, x01_now, q_done, pred_done, upd_done,
        output meas_ready, x00_prev, x01_prev, q_start, pred_start, upd_start,
               busy, step_done, err_tmo, step_cnt
    );

    modport master (
        output meas_valid, x00_now, x01_now, q_done, pred_done, upd_done,
        input  meas_ready, x00_prev, x01_prev, q_start, pred_start, upd_start,
               busy, step_done, err_tmo, step_cnt
    );
endinterface

// File: rtl/kf_step_seq.sv
// kf_step_seq: runs the Q, predict and update stages of one Kalman step in order and
// commits the previous-step state. Define KF_SEQ_TIMEOUT_EN to enable the stage watchdog.
`ifndef FXP_N
`define FXP_N 16
`endif
module kf_step_seq #(
    parameter int N     = `FXP_N,
    parameter int CNT_W = 16
`ifdef KF_SEQ_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input logic          clk,
    input logic          rst_n,
    kf_step_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT_Q = 3'd1;
    localparam logic [2:0] S_WAIT_P = 3'd2;
    localparam logic [2:0] S_WAIT_U = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             q_start_q, q_start_d;
    logic             pred_start_q, pred_start_d;
    logic             upd_start_q, upd_start_d;
    logic             step_done_q, step_done_d;
    logic [N-1:0]     snap0_q, snap0_d, snap1_q, snap1_d;
    logic [N-1:0]     prev0_q, prev0_d, prev1_q, prev1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef KF_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          err_tmo_q, err_tmo_d;
`endif

    always_comb begin
        state_d      = state_q;
        q_start_d    = 1'b0;
        pred_start_d = 1'b0;
        upd_start_d  = 1'b0;
        step_done_d  = 1'b0;
        snap0_d      = snap0_q;
        snap1_d      = snap1_q;
        prev0_d      = prev0_q;
        prev1_d      = prev1_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: if (bus.meas_valid) begin
                snap0_d   = bus.x00_now;
                snap1_d   = bus.x01_now;
                q_start_d = 1'b1;
                state_d   = S_WAIT_Q;
            end
            S_WAIT_Q: if (bus.q_done) begin
                pred_start_d = 1'b1;
                state_d      = S_WAIT_P;
            end
            S_WAIT_P: if (bus.pred_done) begin
                upd_start_d = 1'b1;
                state_d     = S_WAIT_U;
            end
            S_WAIT_U: if (bus.upd_done) begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // First COMMIT cycle writes the state; the second carries step_done, so
                // meas_ready only reappears the cycle after the pulse.
                if (!step_done_q) begin
                    prev0_d     = snap0_q;
                    prev1_d     = snap1_q;
                    cnt_d       = cnt_q + 1'b1;
                    step_done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef KF_SEQ_TIMEOUT_EN
        err_tmo_d = 1'b0;
        if ((state_q == S_WAIT_Q || state_q == S_WAIT_P || state_q == S_WAIT_U) &&
            state_d == state_q && wait_q == TW'(TMO_CYC - 1)) begin
            state_d   = S_IDLE;
            err_tmo_d = 1'b1;
        end
        // Any state change restarts the count, so every WAIT entry begins at zero.
        wait_d = (state_d != state_q) ? '0 : wait_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            q_start_q    <= 1'b0;
            pred_start_q <= 1'b0;
            upd_start_q  <= 1'b0;
            step_done_q  <= 1'b0;
            snap0_q      <= '0;
            snap1_q      <= '0;
            prev0_q      <= '0;
            prev1_q      <= '0;
            cnt_q        <= '0;
`ifdef KF_SEQ_TIMEOUT_EN
            wait_q       <= '0;
            err_tmo_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            q_start_q    <= q_start_d;
            pred_start_q <= pred_start_d;
            upd_start_q  <= upd_start_d;
            step_done_q  <= step_done_d;
            snap0_q      <= snap0_d;
            snap1_q      <= snap1_d;
            prev0_q      <= prev0_d;
            prev1_q      <= prev1_d;
            cnt_q        <= cnt_d;
`ifdef KF_SEQ_TIMEOUT_EN
            wait_q       <= wait_d;
            err_tmo_q    <= err_tmo_d;
`endif
        end
    end

    assign bus.meas_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.q_start    = q_start_q;
    assign bus.pred_start = pred_start_q;
    assign bus.upd_start  = upd_start_q;
    assign bus.step_done  = step_done_q;
    assign bus.x00_prev   = prev0_q;
    assign bus.x01_prev   = prev1_q;
    assign bus.step_cnt   = cnt_q;
`ifdef KF_SEQ_TIMEOUT_EN
    assign bus.err_tmo    = err_tmo_q;
`else
    assign bus.err_tmo    = 1'b0;
`endif
endmodule
